// File: rtl/logic_pipe_pkg.sv
// Shared definitions for the logic_pipe unit: operation encodings and the
// bitwise operation function used by the first pipeline stage.
package logic_pipe_pkg;

    // Widest operand the op function handles; callers zero-extend and truncate.
    localparam int unsigned MAX_W = 256;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    // Apply the selected bitwise operation across the full vector width.
    function automatic logic [MAX_W-1:0] op_apply(
        input logic [1:0]       op,
        input logic [MAX_W-1:0] x,
        input logic [MAX_W-1:0] y
    );
        op_apply = '0;
        case (op)
            OP_AND:  op_apply = x & y;
            OP_OR:   op_apply = x | y;
            OP_XOR:  op_apply = x ^ y;
            OP_NAND: op_apply = ~(x & y);
            default: op_apply = '0;
        endcase
    endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One slot of the logic_pipe pipeline: valid/data register plus its
// next-state logic. The slot loads whenever it is empty or its contents
// are leaving, which lets bubbles collapse behind a stalled tail.
module logic_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    input  logic         down_ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         ready
);

    logic         valid_nxt;
    logic [W-1:0] data_nxt;

    assign ready = !valid || down_ready;

    // Next-state: take the upstream beat when loading; data only moves on a real beat.
    always_comb begin
        valid_nxt = valid;
        data_nxt  = data;
        if (ready) begin
            valid_nxt = up_valid;
            if (up_valid) begin
                data_nxt = up_data;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= valid_nxt;
            data  <= data_nxt;
        end
    end

endmodule

// File: rtl/logic_pipe.sv
// Pipelined W-bit bitwise logic unit with valid/ready flow control.
// Stage 0 registers f(op, a, b); later stages carry the result unchanged.
// out_cnt counts completed output transfers modulo 2^CW.
module logic_pipe
    import logic_pipe_pkg::*;
#(
    parameter int W      = 8,
    parameter int STAGES = 2,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [1:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_cnt
);

    // Element 0 is the input side, element STAGES the output side.
    logic         chain_v [0:STAGES];
    logic [W-1:0] chain_d [0:STAGES];
    logic         chain_r [0:STAGES];

    assign chain_v[0]      = in_valid;
    assign chain_d[0]      = W'(op_apply(op, MAX_W'(a), MAX_W'(b)));
    assign chain_r[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic_pipe_stage #(
            .W(W)
        ) u_stage (
            .clk        (clk),
            .reset_n    (reset_n),
            .up_valid   (chain_v[i]),
            .up_data    (chain_d[i]),
            .down_ready (chain_r[i+1]),
            .valid      (chain_v[i+1]),
            .data       (chain_d[i+1]),
            .ready      (chain_r[i])
        );
    end

    assign in_ready  = chain_r[0] && reset_n;
    assign out_valid = chain_v[STAGES];
    assign out_data  = chain_d[STAGES];

    // Count completed output transfers; wraps naturally at 2^CW.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_cnt <= '0;
        end else if (out_valid && out_ready) begin
            out_cnt <= out_cnt + 1'b1;
        end
    end

endmodule
